// File: rtl/fpu_op_sequencer.sv
// Command sequencer for the Q8.23 add/mul/div unit: accepts one command at a time,
// drives operands and the divide start pulse, then returns the result with its tag.
module fpu_op_sequencer #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned FIX_LAT     = 1,
   parameter int unsigned DIV_TIMEOUT = 64,
   parameter int unsigned TAG_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   // command channel
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   // arithmetic unit side
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   output logic             alu_start,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_done,
   // response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic [7:0]       err_count
);

   localparam int unsigned CNT_W  = (FIX_LAT > 1) ? $clog2(FIX_LAT + 1) : 1;
   localparam int unsigned TCNT_W = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;

   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(FIX_LAT);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DIV_TIMEOUT - 1);
   localparam logic [7:0]        ERR_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FIX = 2'd1,
      WAIT_DIV = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [WIDTH-1:0]    alu_a_d, alu_b_d;
   logic [1:0]          alu_op_d;
   logic                alu_start_d;
   logic                rsp_valid_d;
   logic [WIDTH-1:0]    rsp_data_d;
   logic [TAG_W-1:0]    rsp_tag_d;
   logic                rsp_err_d;
   logic                err_bump;
   logic [7:0]          err_count_d;

   assign cmd_ready = (state_q == IDLE);

   // State and all registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tcnt_q    <= '0;
         tag_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= OP_ADD;
         alu_start <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tcnt_q    <= tcnt_d;
         tag_q     <= tag_d;
         alu_a     <= alu_a_d;
         alu_b     <= alu_b_d;
         alu_op    <= alu_op_d;
         alu_start <= alu_start_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_tag   <= rsp_tag_d;
         rsp_err   <= rsp_err_d;
         err_count <= err_count_d;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      tag_d       = tag_q;
      alu_a_d     = alu_a;
      alu_b_d     = alu_b;
      alu_op_d    = alu_op;
      alu_start_d = 1'b0;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      rsp_tag_d   = rsp_tag;
      rsp_err_d   = rsp_err;
      err_bump    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               alu_a_d = cmd_a;
               alu_b_d = cmd_b;
               tag_d   = cmd_tag;
               case (cmd_op)
                  OP_ADD, OP_MUL: begin
                     alu_op_d = cmd_op;
                     cnt_d    = CNT_LOAD;
                     state_d  = WAIT_FIX;
                  end
                  OP_DIV: begin
                     alu_op_d    = cmd_op;
                     alu_start_d = 1'b1;
                     tcnt_d      = '0;
                     state_d     = WAIT_DIV;
                  end
                  default: begin
                     // Illegal opcode: answer straight away, the unit is left alone
                     rsp_data_d  = '0;
                     rsp_err_d   = 1'b1;
                     rsp_tag_d   = cmd_tag;
                     rsp_valid_d = 1'b1;
                     err_bump    = 1'b1;
                     state_d     = RESP;
                  end
               endcase
            end
         end

         WAIT_FIX: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_data_d  = alu_c;
               rsp_err_d   = 1'b0;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end

         WAIT_DIV: begin
            tcnt_d = tcnt_q + TCNT_W'(1);
            // Done is ignored while the start pulse is still out; done beats timeout
            if (alu_done && !alu_start) begin
               rsp_data_d  = alu_c;
               rsp_err_d   = 1'b0;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end else if (tcnt_q == TCNT_LAST) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_tag_d   = tag_q;
               rsp_valid_d = 1'b1;
               err_bump    = 1'b1;
               state_d     = RESP;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating error-response counter
   always_comb begin
      err_count_d = err_count;
      if (err_bump && (err_count != ERR_MAX)) begin
         err_count_d = err_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: edge-counting transaction model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fpu_op_sequencer;

   localparam int unsigned WIDTH       = 32;
   localparam int unsigned FIX_LAT     = 1;
   localparam int unsigned DIV_TIMEOUT = 64;
   localparam int unsigned TAG_W       = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a = '0;
   logic [WIDTH-1:0] cmd_b = '0;
   logic [1:0]       cmd_op = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [1:0]       alu_op;
   logic             alu_start;
   logic [WIDTH-1:0] alu_c = '0;
   logic             alu_done = 1'b0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [WIDTH-1:0] rsp_data;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;
   logic [7:0]       err_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpu_op_sequencer #(
      .WIDTH(WIDTH), .FIX_LAT(FIX_LAT), .DIV_TIMEOUT(DIV_TIMEOUT), .TAG_W(TAG_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
      .alu_c(alu_c), .alu_done(alu_done),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_err(rsp_err), .err_count(err_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: tracks the edge number at which each response is due
   int               n;
   bit               m_idle, m_pend, m_valid, m_start, m_err;
   logic [1:0]       m_kind, m_op;
   int               m_due, m_dstart, m_errcnt;
   logic [WIDTH-1:0] m_a, m_b, m_data;
   logic [TAG_W-1:0] m_tag, m_tagq;

   task automatic m_respond(input logic [WIDTH-1:0] d, input bit e);
      m_pend  = 1'b0;
      m_valid = 1'b1;
      m_data  = d;
      m_err   = e;
      m_tag   = m_tagq;
      if (e && m_errcnt < 255) m_errcnt++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n = 0; m_idle = 1'b1; m_pend = 1'b0; m_valid = 1'b0; m_start = 1'b0; m_err = 1'b0;
         m_kind = '0; m_op = '0; m_due = 0; m_dstart = 0; m_errcnt = 0;
         m_a = '0; m_b = '0; m_data = '0; m_tag = '0; m_tagq = '0;
      end else begin
         n++;
         m_start = 1'b0;
         if (m_valid) begin
            if (rsp_ready) begin
               m_valid = 1'b0;
               m_idle  = 1'b1;
            end
         end else if (m_idle) begin
            if (cmd_valid) begin
               m_idle = 1'b0;
               m_a    = cmd_a;
               m_b    = cmd_b;
               m_tagq = cmd_tag;
               if (cmd_op == 2'b11) begin
                  m_respond('0, 1'b1);
               end else begin
                  m_op   = cmd_op;
                  m_kind = cmd_op;
                  m_pend = 1'b1;
                  if (cmd_op == 2'b10) begin
                     m_start  = 1'b1;
                     m_dstart = n;
                  end else begin
                     m_due = n + int'(FIX_LAT) + 1;
                  end
               end
            end
         end else if (m_pend) begin
            if (m_kind == 2'b10) begin
               if (alu_done && n >= m_dstart + 2) m_respond(alu_c, 1'b0);
               else if (n == m_dstart + int'(DIV_TIMEOUT)) m_respond('0, 1'b1);
            end else if (n == m_due) begin
               m_respond(alu_c, 1'b0);
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      check("cmd_ready", 32'(cmd_ready), 32'(m_idle));
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("alu_start", 32'(alu_start), 32'(m_start));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("err_count", 32'(err_count), 32'(m_errcnt));
      if (m_valid) begin
         check("rsp_data", rsp_data, m_data);
         check("rsp_tag", 32'(rsp_tag), 32'(m_tag));
         check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
   end

   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
      int w = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("cmd_ready_seen", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Called just after the accept edge; optionally pulses alu_done sampled on edge done_at
   task automatic wait_rsp(input int done_at, input logic [WIDTH-1:0] c,
                           output int edges, output int starts);
      edges = 0;
      starts = 0;
      while (!rsp_valid && edges < 200) begin
         if (alu_start) starts++;
         if (edges == done_at - 1) begin
            alu_done = 1'b1;
            alu_c    = c;
         end else begin
            alu_done = 1'b0;
         end
         @(negedge clk);
         edges++;
      end
      alu_done = 1'b0;
      check("rsp_seen", 32'(rsp_valid), 32'd1);
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run exceeded time limit, got no end expected end");
      $fatal(1);
   end

   initial begin
      int e, s;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Add 1.0 + 1.5 = 2.5
      alu_c = 32'h0140_0000;
      send(2'b00, 32'h0080_0000, 32'h00C0_0000, 4'd3);
      wait_rsp(0, '0, e, s);
      check("add_latency", 32'(e), 32'd2);
      check("add_starts", 32'(s), 32'd0);
      check("add_data", rsp_data, 32'h0140_0000);
      check("add_tag", 32'(rsp_tag), 32'd3);
      check("add_err", 32'(rsp_err), 32'd0);
      consume();

      // Mul 1.0 * 1.5, then backpressure with a queued add
      alu_c = 32'h00C0_0000;
      send(2'b01, 32'h0080_0000, 32'h00C0_0000, 4'd5);
      wait_rsp(0, '0, e, s);
      check("mul_latency", 32'(e), 32'd2);
      alu_c = 32'h0100_0000;
      cmd_a = 32'h0080_0000; cmd_b = 32'h0080_0000; cmd_op = 2'b00; cmd_tag = 4'd9;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_data", rsp_data, 32'h00C0_0000);
         check("bp_tag", 32'(rsp_tag), 32'd5);
         check("bp_ready", 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("bp_after_hs_valid", 32'(rsp_valid), 32'd0);
      check("bp_after_hs_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_accepted", 32'(cmd_ready), 32'd0);
      check("bp_alu_b", alu_b, 32'h0080_0000);
      wait_rsp(0, '0, e, s);
      check("bp_add_latency", 32'(e), 32'd2);
      check("bp_add_data", rsp_data, 32'h0100_0000);
      check("bp_add_tag", 32'(rsp_tag), 32'd9);
      consume();

      // Div 1.0 / 2.0 = 0.5, done sampled 10 edges after start
      send(2'b10, 32'h0080_0000, 32'h0100_0000, 4'd4);
      wait_rsp(10, 32'h0040_0000, e, s);
      check("div_latency", 32'(e), 32'd10);
      check("div_starts", 32'(s), 32'd1);
      check("div_data", rsp_data, 32'h0040_0000);
      check("div_err", 32'(rsp_err), 32'd0);
      consume();

      // Div timeout
      send(2'b10, 32'h0080_0000, 32'h0000_0000, 4'd6);
      wait_rsp(0, '0, e, s);
      check("to_latency", 32'(e), 32'd64);
      check("to_data", rsp_data, 32'd0);
      check("to_err", 32'(rsp_err), 32'd1);
      check("to_tag", 32'(rsp_tag), 32'd6);
      check("to_err_count", 32'(err_count), 32'd1);
      consume();

      // Done and timeout on the same edge: done wins
      send(2'b10, 32'h0080_0000, 32'h0200_0000, 4'd2);
      wait_rsp(64, 32'h0020_0000, e, s);
      check("tie_latency", 32'(e), 32'd64);
      check("tie_err", 32'(rsp_err), 32'd0);
      check("tie_data", rsp_data, 32'h0020_0000);
      check("tie_err_count", 32'(err_count), 32'd1);
      consume();

      // Done while start is still high is ignored -> times out
      send(2'b10, 32'h0080_0000, 32'h0100_0000, 4'd8);
      wait_rsp(1, 32'h0040_0000, e, s);
      check("early_done_latency", 32'(e), 32'd64);
      check("early_done_err", 32'(rsp_err), 32'd1);
      check("early_done_err_count", 32'(err_count), 32'd2);
      consume();

      // Illegal opcode
      send(2'b11, 32'h1111_1111, 32'h2222_2222, 4'd7);
      wait_rsp(0, '0, e, s);
      check("ill_latency", 32'(e), 32'd0);
      check("ill_data", rsp_data, 32'd0);
      check("ill_err", 32'(rsp_err), 32'd1);
      check("ill_tag", 32'(rsp_tag), 32'd7);
      check("ill_alu_op", 32'(alu_op), 32'd2);
      check("ill_err_count", 32'(err_count), 32'd3);
      consume();

      // Saturation
      for (int i = 0; i < 300; i++) begin
         send(2'b11, 32'(i), 32'(i), 4'(i));
         wait_rsp(0, '0, e, s);
         consume();
      end
      check("sat_err_count", 32'(err_count), 32'd255);

      // Reset in the middle of a divide, stray done afterwards
      send(2'b10, 32'h0080_0000, 32'h0100_0000, 4'd1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_start", 32'(alu_start), 32'd0);
      check("mid_rst_alu_a", alu_a, 32'd0);
      check("mid_rst_alu_op", 32'(alu_op), 32'd0);
      check("mid_rst_rsp_data", rsp_data, 32'd0);
      check("mid_rst_rsp_tag", 32'(rsp_tag), 32'd0);
      check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
      check("mid_rst_err_count", 32'(err_count), 32'd0);
      rst_n = 1'b1;
      alu_done = 1'b1;
      alu_c = 32'h1234_5678;
      @(negedge clk);
      alu_done = 1'b0;
      repeat (2) @(negedge clk);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);

      alu_c = 32'h0140_0000;
      send(2'b00, 32'h0080_0000, 32'h00C0_0000, 4'd3);
      wait_rsp(0, '0, e, s);
      check("post_rst_latency", 32'(e), 32'd2);
      check("post_rst_data", rsp_data, 32'h0140_0000);
      check("post_rst_tag", 32'(rsp_tag), 32'd3);
      consume();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
